gen_crd_rr_arb: RTL and testbench
=================================

Name: gen_crd_rr_arb

Overview:
- Round-robin arbiter that shares one credit-controlled downstream resource between N_REQ requesters, for example the entries of a target FIFO.
- Keeps an internal credit count. Each grant consumes one credit; the downstream returns credits through a return port.
- Grants at most one requester per cycle and issues a registered transfer (valid + requester id) toward the resource.

Parameters:
- N_REQ, 4, number of requesters (1..32).
- CRD_INIT_AMOUNT, 8, credits held after reset; this is also the maximum count.
- MAX_CRD_RET_VAL, 1, maximum credits returned in one cycle.
- CNT_W, $clog2(CRD_INIT_AMOUNT)+1, credit count width (derived).
- RET_W, $clog2(MAX_CRD_RET_VAL)+1, return value width (derived).
- ID_W, max(1,$clog2(N_REQ)), requester id width (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- arb_en  in  1  arbitration enable; when 0, no grants are issued.
- req_vld  in  N_REQ  per-requester request.
- req_rdy  out  N_REQ  one-hot grant (combinational); a transfer completes when req_vld[i] & req_rdy[i].
- crd_ret_en  in  1  credit return enable.
- crd_ret_val  in  RET_W  number of credits returned.
- out_vld  out  1  registered transfer valid toward the resource.
- out_id  out  ID_W  registered id of the granted requester.
- crd_cnt  out  CNT_W  current available credits.
- crd_exist  out  1  crd_cnt != 0.
- err_ovf  out  1  sticky flag: a return pushed the count above CRD_INIT_AMOUNT.
- err_ret  out  1  sticky flag: crd_ret_val > MAX_CRD_RET_VAL while crd_ret_en=1.

Behaviour:
- Reset values:
  - crd_cnt = CRD_INIT_AMOUNT.
  - out_vld=0, out_id=0, err_ovf=0, err_ret=0.
  - rr_ptr = N_REQ-1, so requester 0 has first priority.
- Reset asserted mid-operation clears state immediately. A transfer in flight is dropped and credits are not restored beyond the reset value.
- Grant condition: arb_en & crd_exist & |req_vld.
  - Winner = first i with req_vld[i]=1, scanning from rr_ptr+1 upward and wrapping at N_REQ-1 to 0.
  - req_rdy is one-hot on the winner and all-zero otherwise.
  - req_rdy depends combinationally on req_vld, rr_ptr, crd_cnt and arb_en only. It never depends on the same-cycle crd_ret_en.
- Pointer: on a grant, rr_ptr <= winner next cycle; otherwise it holds.
- Output: out_vld <= grant; out_id <= winner on a grant, else holds. Latency is one cycle from grant to out_vld.
- Credit update, per cycle, with inc = crd_ret_en ? crd_ret_val : 0 and dec = grant ? 1 : 0:
  - crd_cnt_next = crd_cnt + inc - dec, computed at CNT_W+1 bits.
  - If the result exceeds CRD_INIT_AMOUNT: clamp to CRD_INIT_AMOUNT and set err_ovf.
  - Returned credits are usable from the next cycle only, so a grant is never issued at crd_cnt=0 even with a same-cycle return.
  - Simultaneous grant and return are both applied in the same cycle.
- crd_exist is combinational from the registered crd_cnt.
- err_ret is set when crd_ret_en & (crd_ret_val > MAX_CRD_RET_VAL); the value is still applied, subject to the clamp. Both error flags clear only on reset.
- Underflow is impossible by construction; it is checked by assertion.
- N_REQ=1: rr_ptr is constant 0 and out_id is always 0.
- A requester may drop req_vld without a grant; no lock is held.

Test Plan:
- Reset, then all 4 req_vld=1 with arb_en=1 -> grants 0,1,2,3,0,... one per cycle for 8 cycles; crd_cnt goes 8→0; out_vld follows each grant by 1 cycle with out_id matching; req_rdy=0 from cycle 9.
- crd_cnt=0, req_vld[2]=1, crd_ret_en=1 with val=1 in cycle T -> no grant in T; req_rdy[2]=1 in T+1; crd_cnt 0→1→0.
- crd_cnt=3, a grant plus a return of 1 in the same cycle -> crd_cnt stays 3; err flags stay 0.
- crd_cnt=8, return of 1 -> crd_cnt stays 8; err_ovf=1 sticky until rst_n=0.
- Only req_vld[1] and req_vld[3] set, rr_ptr=1 -> winner 3, then 1, then 3; requesters 0 and 2 never granted.
- arb_en=0 with requests pending -> req_rdy=0, crd_cnt unchanged. Assert rst_n=0 asynchronously mid-burst -> out_vld=0 and crd_cnt=8 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/gen_crd_rr_arb.sv
// Credit-controlled round-robin arbiter: shares one downstream resource between
// N_REQ requesters, spending one credit per grant and reclaiming returned credits.
module gen_crd_rr_arb #(
    parameter int N_REQ           = 4,
    parameter int CRD_INIT_AMOUNT = 8,
    parameter int MAX_CRD_RET_VAL = 1,
    parameter int CNT_W           = $clog2(CRD_INIT_AMOUNT) + 1,
    parameter int RET_W           = $clog2(MAX_CRD_RET_VAL) + 1,
    parameter int ID_W            = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arb_en,
    input  logic [N_REQ-1:0] req_vld,
    output logic [N_REQ-1:0] req_rdy,
    input  logic             crd_ret_en,
    input  logic [RET_W-1:0] crd_ret_val,
    output logic             out_vld,
    output logic [ID_W-1:0]  out_id,
    output logic [CNT_W-1:0] crd_cnt,
    output logic             crd_exist,
    output logic             err_ovf,
    output logic             err_ret
);

    localparam logic [CNT_W:0]   CRD_MAX   = (CNT_W+1)'(CRD_INIT_AMOUNT);
    localparam logic [RET_W-1:0] RET_LIMIT = RET_W'(MAX_CRD_RET_VAL);
    localparam logic [ID_W-1:0]  PTR_RST   = ID_W'(N_REQ - 1);

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  win_id;
    logic             win_found;
    logic             grant;
    logic [CNT_W:0]   inc;
    logic [CNT_W:0]   dec;
    logic [CNT_W:0]   crd_sum;
    logic             ovf;

    assign crd_exist = (crd_cnt != '0);

    // Scan upward from the requester after the last winner, wrapping to 0.
    always_comb begin
        int idx;
        idx       = 0;
        win_id    = '0;
        win_found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!win_found && req_vld[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    // Same-cycle returns are deliberately excluded: only registered credits grant.
    assign grant = arb_en & crd_exist & win_found;

    always_comb begin
        req_rdy = '0;
        if (grant) begin
            req_rdy[win_id] = 1'b1;
        end
    end

    always_comb begin
        inc     = crd_ret_en ? (CNT_W+1)'(crd_ret_val) : '0;
        dec     = grant ? (CNT_W+1)'(1) : '0;
        crd_sum = {1'b0, crd_cnt} + inc - dec;
        ovf     = (crd_sum > CRD_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crd_cnt <= CNT_W'(CRD_INIT_AMOUNT);
            rr_ptr  <= PTR_RST;
            out_vld <= 1'b0;
            out_id  <= '0;
            err_ovf <= 1'b0;
            err_ret <= 1'b0;
        end else begin
            assert (!(grant && crd_cnt == '0));
            crd_cnt <= ovf ? CRD_MAX[CNT_W-1:0] : crd_sum[CNT_W-1:0];
            out_vld <= grant;
            if (grant) begin
                rr_ptr <= win_id;
                out_id <= win_id;
            end
            if (ovf) begin
                err_ovf <= 1'b1;
            end
            if (crd_ret_en && (crd_ret_val > RET_LIMIT)) begin
                err_ret <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gen_crd_rr_arb.sv
// Directed bench for gen_crd_rr_arb: round-robin order, credit accounting,
// overflow clamp, arb_en gating and asynchronous reset.
module tb_gen_crd_rr_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       arb_en;
    logic [3:0] req_vld;
    logic [3:0] req_rdy;
    logic       crd_ret_en;
    logic [0:0] crd_ret_val;
    logic       out_vld;
    logic [1:0] out_id;
    logic [3:0] crd_cnt;
    logic       crd_exist;
    logic       err_ovf;
    logic       err_ret;

    int checks = 0;
    int errors = 0;

    gen_crd_rr_arb dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req_vld(req_vld),
        .req_rdy(req_rdy), .crd_ret_en(crd_ret_en), .crd_ret_val(crd_ret_val),
        .out_vld(out_vld), .out_id(out_id), .crd_cnt(crd_cnt),
        .crd_exist(crd_exist), .err_ovf(err_ovf), .err_ret(err_ret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 2 time units after each rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; arb_en = 1'b0; req_vld = 4'h0;
        crd_ret_en = 1'b0; crd_ret_val = 1'b0;
        #12;
        chk("rst_crd_cnt", 32'(crd_cnt), 32'd8);
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_err_ovf", 32'(err_ovf), 32'd0);
        chk("rst_err_ret", 32'(err_ret), 32'd0);
        chk("rst_crd_exist", 32'(crd_exist), 32'd1);
        rst_n = 1'b1;
        tick();

        // Full burst: all request, grants 0,1,2,3,0,1,2,3 as credits drain 8 -> 0.
        req_vld = 4'hF; arb_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("burst_rdy", 32'(req_rdy), 32'(4'b0001 << (i % 4)));
            chk("burst_cnt", 32'(crd_cnt), 32'(8 - i));
            chk("burst_vld", 32'(out_vld), (i > 0) ? 32'd1 : 32'd0);
            if (i > 0) chk("burst_id", 32'(out_id), 32'((i - 1) % 4));
            tick();
        end
        chk("drain_cnt", 32'(crd_cnt), 32'd0);
        chk("drain_exist", 32'(crd_exist), 32'd0);
        chk("drain_rdy", 32'(req_rdy), 32'd0);
        chk("drain_vld", 32'(out_vld), 32'd1);
        chk("drain_id", 32'(out_id), 32'd3);
        tick();
        chk("idle_vld", 32'(out_vld), 32'd0);
        chk("idle_id_hold", 32'(out_id), 32'd3);

        // Return at zero credits is usable only from the next cycle.
        req_vld = 4'b0100; crd_ret_en = 1'b1; crd_ret_val = 1'b1;
        #1;
        chk("ret0_rdy", 32'(req_rdy), 32'd0);
        tick();
        crd_ret_en = 1'b0;
        #1;
        chk("ret1_cnt", 32'(crd_cnt), 32'd1);
        chk("ret1_rdy", 32'(req_rdy), 32'b0100);
        tick();
        chk("ret2_cnt", 32'(crd_cnt), 32'd0);
        chk("ret2_vld", 32'(out_vld), 32'd1);
        chk("ret2_id", 32'(out_id), 32'd2);

        // Refill to 3, then grant and return together: count holds.
        req_vld = 4'h0; crd_ret_en = 1'b1;
        tick(); tick(); tick();
        chk("fill3_cnt", 32'(crd_cnt), 32'd3);
        req_vld = 4'b0001;
        #1;
        chk("both_rdy", 32'(req_rdy), 32'b0001);
        tick();
        chk("both_cnt", 32'(crd_cnt), 32'd3);
        chk("both_id", 32'(out_id), 32'd0);
        chk("both_ovf", 32'(err_ovf), 32'd0);
        chk("both_ret", 32'(err_ret), 32'd0);

        // Move pointer to 1, then alternate between requesters 1 and 3.
        req_vld = 4'b0010; crd_ret_en = 1'b0;
        #1;
        chk("ptr1_rdy", 32'(req_rdy), 32'b0010);
        tick();
        chk("ptr1_cnt", 32'(crd_cnt), 32'd2);
        req_vld = 4'b1010; crd_ret_en = 1'b1;
        #1;
        chk("alt_rdy_a", 32'(req_rdy), 32'b1000);
        tick();
        chk("alt_id_a", 32'(out_id), 32'd3);
        chk("alt_rdy_b", 32'(req_rdy), 32'b0010);
        tick();
        chk("alt_id_b", 32'(out_id), 32'd1);
        chk("alt_rdy_c", 32'(req_rdy), 32'b1000);
        tick();
        chk("alt_id_c", 32'(out_id), 32'd3);
        chk("alt_cnt", 32'(crd_cnt), 32'd2);

        // Refill to full, then one more return overflows and sets the sticky flag.
        req_vld = 4'h0;
        for (int i = 0; i < 6; i++) tick();
        chk("full_cnt", 32'(crd_cnt), 32'd8);
        chk("full_ovf", 32'(err_ovf), 32'd0);
        tick();
        chk("ovf_cnt", 32'(crd_cnt), 32'd8);
        chk("ovf_flag", 32'(err_ovf), 32'd1);
        crd_ret_en = 1'b0;
        tick(); tick();
        chk("ovf_sticky", 32'(err_ovf), 32'd1);

        // arb_en low blocks grants.
        arb_en = 1'b0; req_vld = 4'hF;
        #1;
        chk("dis_rdy", 32'(req_rdy), 32'd0);
        tick();
        chk("dis_cnt", 32'(crd_cnt), 32'd8);
        chk("dis_vld", 32'(out_vld), 32'd0);

        // Mid-burst asynchronous reset.
        arb_en = 1'b1;
        tick(); tick();
        chk("pre_rst_cnt", 32'(crd_cnt), 32'd6);
        chk("pre_rst_vld", 32'(out_vld), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_vld", 32'(out_vld), 32'd0);
        chk("async_rst_cnt", 32'(crd_cnt), 32'd8);
        chk("async_rst_ovf", 32'(err_ovf), 32'd0);
        chk("async_rst_id", 32'(out_id), 32'd0);
        #10;
        rst_n = 1'b1;
        #1;
        chk("post_rst_rdy", 32'(req_rdy), 32'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
